// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the pipelined control unit: control-word layout,
// field encodings, DLX opcode table and the opcode legality check.
package ctrl_pkg;

  localparam int CTRL_W = 26;

  // Bit offsets of the control-word fields (LSB = 0).
  localparam int OFF_EXT_MEM     = 0;
  localparam int OFF_MEM_WE      = 1;
  localparam int OFF_MEM_SIZE    = 2;
  localparam int OFF_EXT_IMM     = 4;
  localparam int OFF_ALU_SRC     = 5;
  localparam int OFF_FPU_OP      = 6;
  localparam int OFF_ALU_CRUFT   = 9;
  localparam int OFF_ALU_OP      = 11;
  localparam int OFF_FP_SRC      = 14;
  localparam int OFF_BRANCH_COND = 15;
  localparam int OFF_COND_SRC    = 16;
  localparam int OFF_JUMP_TYPE   = 17;
  localparam int OFF_REG_DEST    = 19;
  localparam int OFF_FP_DEST     = 20;
  localparam int OFF_REG_WE      = 21;
  localparam int OFF_DIN_SRC     = 22;

  // The listed fields fill 24 bits; the top two bits are reserved and stay zero.
  typedef struct packed {
    logic [1:0] rsvd;
    logic [1:0] din_src;
    logic       reg_we;
    logic       fp_dest;
    logic       reg_dest;
    logic [1:0] jump_type;
    logic       cond_src;
    logic       branch_cond;
    logic       fp_src;
    logic [2:0] alu_op;
    logic [1:0] alu_cruft;
    logic [2:0] fpu_op;
    logic       alu_src;
    logic       ext_imm;
    logic [1:0] mem_size;
    logic       mem_we;
    logic       ext_mem;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [1:0] DINSRC_ALU  = 2'b00;
  localparam logic [1:0] DINSRC_MEM  = 2'b01;
  localparam logic [1:0] DINSRC_LINK = 2'b10;

  localparam logic [1:0] JMP_NONE   = 2'b00;
  localparam logic [1:0] JMP_BRANCH = 2'b01;
  localparam logic [1:0] JMP_DIRECT = 2'b10;
  localparam logic [1:0] JMP_REG    = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  localparam logic [2:0] FPU_NONE = 3'b000;
  localparam logic [2:0] FPU_ADD  = 3'b001;
  localparam logic [2:0] FPU_SUB  = 3'b010;
  localparam logic [2:0] FPU_MUL  = 3'b011;
  localparam logic [2:0] FPU_DIV  = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_FTYPE = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_BFPT  = 6'h06;
  localparam logic [5:0] OP_BFPF  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // True when the opcode appears in the decode table.
  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_FTYPE, OP_J, OP_JAL, OP_BEQZ, OP_BNEZ, OP_BFPT, OP_BFPF,
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_JR, OP_JALR,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default:                                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-side request and per-stage control outputs of the pipelined control unit.
interface ctrl_pipe_if
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [5:0]        OpCode;
  logic [5:0]        Function;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              flush;
  logic              stall;
  logic              ex_valid;
  logic              mem_valid;
  logic              wb_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [CTRL_W-1:0] wb_ctrl;
  logic [REG_AW-1:0] ex_rd;
  logic [REG_AW-1:0] mem_rd;
  logic [REG_AW-1:0] wb_rd;
  logic              illegal;

  modport master (
    output id_valid, OpCode, Function, id_rs1, id_rs2, id_rd, flush,
    input  stall, ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_rd, mem_rd, wb_rd, illegal
  );

  modport slave (
    input  id_valid, OpCode, Function, id_rs1, id_rs2, id_rd, flush,
    output stall, ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
           ex_rd, mem_rd, wb_rd, illegal
  );
endinterface

// File: rtl/ctrl_pipe_control.sv
// Combinational DLX decoder: OpCode/Function to the full control word.
module Control
  import ctrl_pkg::*;
(
  input  logic [5:0] OpCode,
  input  logic [5:0] Function,
  output ctrl_t      ctrl
);

  // Decode one instruction; unlisted opcodes decode to the all-zero word.
  always_comb begin
    // NOTE: the default assignment first means every path drives every field, so no latch is inferred.
    ctrl = CTRL_BUBBLE;
    case (OpCode)
      OP_RTYPE: begin
        ctrl.reg_we   = 1'b1;
        ctrl.reg_dest = 1'b1;
        case (Function)
          6'h20:   ctrl.alu_op = ALU_ADD;
          6'h22:   ctrl.alu_op = ALU_SUB;
          6'h24:   ctrl.alu_op = ALU_AND;
          6'h25:   ctrl.alu_op = ALU_OR;
          6'h26:   ctrl.alu_op = ALU_XOR;
          6'h04:   ctrl.alu_op = ALU_SLL;
          6'h06:   ctrl.alu_op = ALU_SRL;
          6'h07:   ctrl.alu_op = ALU_SRA;
          // Set-on-compare ops subtract and let ALUCruft pick the condition.
          6'h28:   begin ctrl.alu_op = ALU_SUB; ctrl.alu_cruft = 2'b01; end
          6'h29:   begin ctrl.alu_op = ALU_SUB; ctrl.alu_cruft = 2'b10; end
          6'h2A:   begin ctrl.alu_op = ALU_SUB; ctrl.alu_cruft = 2'b11; end
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_FTYPE: begin
        ctrl.reg_we   = 1'b1;
        ctrl.fp_dest  = 1'b1;
        ctrl.reg_dest = 1'b1;
        ctrl.fp_src   = 1'b1;
        case (Function)
          6'h00:   ctrl.fpu_op = FPU_ADD;
          6'h01:   ctrl.fpu_op = FPU_SUB;
          6'h02:   ctrl.fpu_op = FPU_MUL;
          6'h03:   ctrl.fpu_op = FPU_DIV;
          default: ctrl.fpu_op = FPU_NONE;
        endcase
      end
      OP_J, OP_JAL: begin
        ctrl.jump_type = JMP_DIRECT;
        ctrl.ext_imm   = 1'b1;
        if (OpCode == OP_JAL) begin
          ctrl.reg_we  = 1'b1;
          ctrl.din_src = DINSRC_LINK;
        end
      end
      OP_BEQZ, OP_BNEZ, OP_BFPT, OP_BFPF: begin
        ctrl.jump_type   = JMP_BRANCH;
        ctrl.ext_imm     = 1'b1;
        ctrl.cond_src    = (OpCode == OP_BFPT) || (OpCode == OP_BFPF);
        ctrl.branch_cond = (OpCode == OP_BNEZ) || (OpCode == OP_BFPT);
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.reg_we  = 1'b1;
        ctrl.alu_src = 1'b1;
        case (OpCode)
          OP_SUBI: begin ctrl.alu_op = ALU_SUB; ctrl.ext_imm = 1'b1; end
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_XORI: ctrl.alu_op = ALU_XOR;
          default: begin ctrl.alu_op = ALU_ADD; ctrl.ext_imm = 1'b1; end
        endcase
      end
      OP_JR, OP_JALR: begin
        ctrl.jump_type = JMP_REG;
        if (OpCode == OP_JALR) begin
          ctrl.reg_we  = 1'b1;
          ctrl.din_src = DINSRC_LINK;
        end
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl.din_src  = DINSRC_MEM;
        ctrl.reg_we   = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.ext_imm  = 1'b1;
        ctrl.mem_size = (OpCode == OP_LW) ? 2'b10 :
                        ((OpCode == OP_LH) || (OpCode == OP_LHU)) ? 2'b01 : 2'b00;
        ctrl.ext_mem  = (OpCode == OP_LB) || (OpCode == OP_LH);
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.mem_we   = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.ext_imm  = 1'b1;
        ctrl.mem_size = (OpCode == OP_SW) ? 2'b10 : (OpCode == OP_SH) ? 2'b01 : 2'b00;
      end
      default: ctrl = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes in ID and carries the control word through
// EX, MEM and WB with valid bits, load-use stall, flush and FP-multiply hold.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FP_MUL_LAT   = 4,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  ctrl_pipe_if.slave   bus
);

  localparam int CNT_W = (FP_MUL_LAT > 1) ? $clog2(FP_MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(FP_MUL_LAT - 1);

  ctrl_t             id_ctrl;
  ctrl_t             ex_ctrl, mem_ctrl, wb_ctrl;
  logic              ex_valid, mem_valid, wb_valid;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic [CNT_W-1:0]  mul_cnt;
  logic              illegal;
  logic              hold, load_use, id_illegal, id_take;

  Control u_control (
    .OpCode   (bus.OpCode),
    .Function (bus.Function),
    .ctrl     (id_ctrl)
  );

  // Hazard evaluation from the current EX registers and the ID inputs.
  always_comb begin
    hold       = (mul_cnt != '0);
    id_illegal = ILLEGAL_TRAP && !op_legal(bus.OpCode);
    // A flushed or trapped ID instruction is discarded, so it never needs to wait.
    load_use   = bus.id_valid && !bus.flush && !id_illegal && ex_valid &&
                 (ex_ctrl.din_src == DINSRC_MEM) && ex_ctrl.reg_we && (ex_rd != '0) &&
                 ((ex_rd == bus.id_rs1) || (ex_rd == bus.id_rs2));
    id_take    = bus.id_valid && !bus.flush && !load_use && !id_illegal;
  end

  assign bus.stall = hold | load_use;

  // Stage advance: WB always takes MEM; EX/MEM freeze only during a multiply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments let every stage read the pre-edge value of the stage before it.
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= CTRL_BUBBLE;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_ctrl  <= CTRL_BUBBLE;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= CTRL_BUBBLE;
      wb_rd     <= '0;
      mul_cnt   <= '0;
      illegal   <= 1'b0;
    end else begin
      wb_valid <= mem_valid;
      wb_ctrl  <= mem_ctrl;
      wb_rd    <= mem_rd;
      if (hold) begin
        mul_cnt   <= mul_cnt - 1'b1;
        mem_valid <= 1'b0;
        mem_ctrl  <= CTRL_BUBBLE;
        mem_rd    <= '0;
        illegal   <= 1'b0;
      end else begin
        mem_valid <= ex_valid;
        mem_ctrl  <= ex_ctrl;
        mem_rd    <= ex_rd;
        ex_valid  <= id_take;
        ex_ctrl   <= id_take ? id_ctrl : CTRL_BUBBLE;
        ex_rd     <= id_take ? bus.id_rd : '0;
        mul_cnt   <= (id_take && (id_ctrl.fpu_op == FPU_MUL)) ? MUL_LOAD : '0;
        illegal   <= bus.id_valid && !bus.flush && id_illegal;
      end
    end
  end

  assign bus.ex_valid  = ex_valid;
  assign bus.mem_valid = mem_valid;
  assign bus.wb_valid  = wb_valid;
  assign bus.ex_ctrl   = ex_ctrl;
  assign bus.mem_ctrl  = mem_ctrl;
  assign bus.wb_ctrl   = wb_ctrl;
  assign bus.ex_rd     = ex_rd;
  assign bus.mem_rd    = mem_rd;
  assign bus.wb_rd     = wb_rd;
  assign bus.illegal   = illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: decode table, WB scoreboard, and
// hand-written hazard / hold / flush / trap / reset sequences.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int REG_AW = 5;
  localparam int LAT    = 4;

  // Expected words, field order:
  // rsvd_din_we_fpd_rdst_jt_cs_bc_fps_aluop_cruft_fpu_asrc_ext_msize_mwe_extm
  localparam logic [25:0] W_ADD  = 26'b00_00_1_0_1_00_0_0_0_000_00_000_0_0_00_0_0;
  localparam logic [25:0] W_SUB  = 26'b00_00_1_0_1_00_0_0_0_001_00_000_0_0_00_0_0;
  localparam logic [25:0] W_LW   = 26'b00_01_1_0_0_00_0_0_0_000_00_000_1_1_10_0_0;
  localparam logic [25:0] W_SW   = 26'b00_00_0_0_0_00_0_0_0_000_00_000_1_1_10_1_0;
  localparam logic [25:0] W_BNEZ = 26'b00_00_0_0_0_01_0_1_0_000_00_000_0_1_00_0_0;
  localparam logic [25:0] W_JAL  = 26'b00_10_1_0_0_10_0_0_0_000_00_000_0_1_00_0_0;
  localparam logic [25:0] W_ADDF = 26'b00_00_1_1_1_00_0_0_1_000_00_001_0_0_00_0_0;
  localparam logic [25:0] W_ORI  = 26'b00_00_1_0_0_00_0_0_0_011_00_000_1_0_00_0_0;
  localparam logic [25:0] W_JR   = 26'b00_00_0_0_0_11_0_0_0_000_00_000_0_0_00_0_0;
  localparam logic [25:0] W_LBU  = 26'b00_01_1_0_0_00_0_0_0_000_00_000_1_1_00_0_0;
  localparam logic [25:0] W_SLT  = 26'b00_00_1_0_1_00_0_0_0_001_11_000_0_0_00_0_0;
  localparam logic [25:0] W_MULF = 26'b00_00_1_1_1_00_0_0_1_000_00_011_0_0_00_0_0;

  typedef struct packed {
    logic [25:0]       ctrl;
    logic [REG_AW-1:0] rd;
  } exp_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [25:0] word;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t got;
  vec_t vecs[11];

  ctrl_pipe_if #(.REG_AW(REG_AW)) bus ();

  ctrl_pipe #(
    .REG_AW       (REG_AW),
    .FP_MUL_LAT   (LAT),
    .ILLEGAL_TRAP (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                       input logic [REG_AW-1:0] rd);
    bus.id_valid = 1'b1;
    bus.OpCode   = op;
    bus.Function = fn;
    bus.id_rs1   = rs1;
    bus.id_rs2   = rs2;
    bus.id_rd    = rd;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0;
    bus.OpCode   = '0;
    bus.Function = '0;
    bus.id_rs1   = '0;
    bus.id_rs2   = '0;
    bus.id_rd    = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic expect_wb(input logic [25:0] w, input logic [REG_AW-1:0] rd);
    exp_q.push_back('{ctrl: w, rd: rd});
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every valid WB slot must match the oldest outstanding instruction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wb_valid) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 32'(bus.wb_valid), 32'd0);
        end else begin
          got = exp_q.pop_front();
          check("wb_ctrl", 32'(bus.wb_ctrl), 32'(got.ctrl));
          check("wb_rd", 32'(bus.wb_rd), 32'(got.rd));
        end
      end else begin
        check("wb_bubble_zero", 32'(bus.wb_ctrl), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0]  = '{"ADD",  6'h00, 6'h20, W_ADD};
    vecs[1]  = '{"SUB",  6'h00, 6'h22, W_SUB};
    vecs[2]  = '{"LW",   6'h23, 6'h00, W_LW};
    vecs[3]  = '{"SW",   6'h2B, 6'h00, W_SW};
    vecs[4]  = '{"BNEZ", 6'h05, 6'h00, W_BNEZ};
    vecs[5]  = '{"JAL",  6'h03, 6'h00, W_JAL};
    vecs[6]  = '{"ADDF", 6'h01, 6'h00, W_ADDF};
    vecs[7]  = '{"ORI",  6'h0D, 6'h00, W_ORI};
    vecs[8]  = '{"JR",   6'h12, 6'h00, W_JR};
    vecs[9]  = '{"LBU",  6'h24, 6'h00, W_LBU};
    vecs[10] = '{"SLT",  6'h00, 6'h2A, W_SLT};

    // Reset state.
    idle();
    repeat (2) @(negedge clk);
    check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
    check("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Decode table, back to back with no dependencies.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].op, vecs[i].fn, '0, '0, REG_AW'(i + 1));
      #1 check({"stall_", vecs[i].name}, 32'(bus.stall), 32'd0);
      expect_wb(vecs[i].word, REG_AW'(i + 1));
      @(negedge clk);
      check({"ex_valid_", vecs[i].name}, 32'(bus.ex_valid), 32'd1);
      check({"ex_ctrl_", vecs[i].name}, 32'(bus.ex_ctrl), 32'(vecs[i].word));
      check({"ex_rd_", vecs[i].name}, 32'(bus.ex_rd), 32'(i + 1));
    end
    drain(4);

    // Load-use: LW r3 then ADD r4,r3,r5.
    drive(6'h23, 6'h00, 5'd0, 5'd0, 5'd3);
    expect_wb(W_LW, 5'd3);
    @(negedge clk);
    drive(6'h00, 6'h20, 5'd3, 5'd5, 5'd4);
    #1 check("lu_stall", 32'(bus.stall), 32'd1);
    expect_wb(W_ADD, 5'd4);
    @(negedge clk);
    check("lu_ex_bubble", 32'(bus.ex_valid), 32'd0);
    check("lu_ex_bubble_ctrl", 32'(bus.ex_ctrl), 32'd0);
    #1 check("lu_stall_once", 32'(bus.stall), 32'd0);
    @(negedge clk);
    check("lu_add_ex_valid", 32'(bus.ex_valid), 32'd1);
    check("lu_add_ex_rd", 32'(bus.ex_rd), 32'd4);
    drain(4);

    // Load into r0 never stalls.
    drive(6'h23, 6'h00, 5'd0, 5'd0, 5'd0);
    expect_wb(W_LW, 5'd0);
    @(negedge clk);
    drive(6'h00, 6'h20, 5'd0, 5'd0, 5'd6);
    #1 check("r0_no_stall", 32'(bus.stall), 32'd0);
    expect_wb(W_ADD, 5'd6);
    @(negedge clk);
    check("r0_add_ex_rd", 32'(bus.ex_rd), 32'd6);
    drain(4);

    // FP multiply hold followed by ADD.
    drive(6'h01, 6'h02, 5'd0, 5'd0, 5'd7);
    expect_wb(W_MULF, 5'd7);
    @(negedge clk);
    drive(6'h00, 6'h20, 5'd0, 5'd0, 5'd8);
    expect_wb(W_ADD, 5'd8);
    for (int k = 0; k < LAT - 1; k++) begin
      #1 check("mul_stall", 32'(bus.stall), 32'd1);
      check("mul_mem_bubble", 32'(bus.mem_valid), 32'd0);
      check("mul_ex_rd", 32'(bus.ex_rd), 32'd7);
      @(negedge clk);
    end
    #1 check("mul_stall_done", 32'(bus.stall), 32'd0);
    check("mul_mem_bubble_last", 32'(bus.mem_valid), 32'd0);
    check("mul_ex_last", 32'(bus.ex_rd), 32'd7);
    @(negedge clk);
    check("mul_add_ex_rd", 32'(bus.ex_rd), 32'd8);
    check("mul_mem_valid", 32'(bus.mem_valid), 32'd1);
    check("mul_mem_rd", 32'(bus.mem_rd), 32'd7);
    drain(4);

    // Flush during a load-use condition.
    drive(6'h23, 6'h00, 5'd0, 5'd0, 5'd9);
    expect_wb(W_LW, 5'd9);
    @(negedge clk);
    drive(6'h00, 6'h20, 5'd9, 5'd0, 5'd10);
    bus.flush = 1'b1;
    #1 check("flush_no_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_ex_bubble", 32'(bus.ex_valid), 32'd0);
    drive(6'h00, 6'h22, 5'd9, 5'd0, 5'd11);
    #1 check("flush_next_no_stall", 32'(bus.stall), 32'd0);
    expect_wb(W_SUB, 5'd11);
    @(negedge clk);
    check("flush_next_ex_rd", 32'(bus.ex_rd), 32'd11);
    drain(4);

    // Illegal opcode trap.
    drive(6'h3F, 6'h00, 5'd0, 5'd0, 5'd12);
    #1 check("ill_no_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    check("ill_pulse", 32'(bus.illegal), 32'd1);
    check("ill_ex_bubble", 32'(bus.ex_valid), 32'd0);
    idle();
    @(negedge clk);
    check("ill_pulse_end", 32'(bus.illegal), 32'd0);
    drain(3);

    // Load-use pair right behind a multiply: hold first, then one load-use cycle.
    drive(6'h01, 6'h02, 5'd0, 5'd0, 5'd13);
    expect_wb(W_MULF, 5'd13);
    @(negedge clk);
    drive(6'h23, 6'h00, 5'd0, 5'd0, 5'd14);
    expect_wb(W_LW, 5'd14);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!bus.stall) break;
      n++;
      @(negedge clk);
    end
    check("mul_lu_hold_cycles", 32'(n), 32'(LAT - 1));
    @(negedge clk);
    check("mul_lu_lw_ex_rd", 32'(bus.ex_rd), 32'd14);
    drive(6'h00, 6'h20, 5'd14, 5'd0, 5'd15);
    #1 check("mul_lu_stall", 32'(bus.stall), 32'd1);
    expect_wb(W_ADD, 5'd15);
    @(negedge clk);
    check("mul_lu_bubble", 32'(bus.ex_valid), 32'd0);
    #1 check("mul_lu_stall_once", 32'(bus.stall), 32'd0);
    @(negedge clk);
    check("mul_lu_add_ex_rd", 32'(bus.ex_rd), 32'd15);
    drain(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset asserted mid-multiply.
    drive(6'h01, 6'h02, 5'd0, 5'd0, 5'd16);
    @(negedge clk);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_mid_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
    check("rst_mid_ex_rd", 32'(bus.ex_rd), 32'd0);
    check("rst_mid_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mid_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_mid_stall", 32'(bus.stall), 32'd0);
    check("rst_mid_illegal", 32'(bus.illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'h00, 6'h20, 5'd0, 5'd0, 5'd17);
    #1 check("post_rst_no_stall", 32'(bus.stall), 32'd0);
    expect_wb(W_ADD, 5'd17);
    @(negedge clk);
    check("post_rst_ex_valid", 32'(bus.ex_valid), 32'd1);
    check("post_rst_ex_rd", 32'(bus.ex_rd), 32'd17);
    drain(4);
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
